// File: rtl/modulo_batalha_naval_param.sv
// Naval-battle board engine: ship/attack maps, shot judging, RGB verdict, counters and LED matrix scan.
// Optional build macro BN_CURSOR_BLINK_EN overlays a blinking attack cursor on the matrix in ATTACK.
module modulo_batalha_naval_param #(
  parameter  int COLS       = 5,
  parameter  int ROWS       = 7,
  parameter  int SCAN_DIV   = 16,
  parameter  int RESULT_CYC = 4,
  localparam int CW         = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int N          = ROWS * COLS,
  localparam int HW         = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [N-1:0]  preset_map,
  input  logic          start,
  input  logic [CW-1:0] at_col,
  input  logic [RW-1:0] at_row,
  input  logic          at_fire,
  output logic          at_ready,
  output logic          at_err,
  output logic [COLS-1:0] m_col,
  output logic [ROWS-1:0] m_line,
  output logic          rgb_r,
  output logic          rgb_g,
  output logic [HW-1:0] hit_count,
  output logic [7:0]    shot_count,
  output logic          game_over
);

  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RCW = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
  localparam int CWP = CW + 1;
  localparam int RWP = RW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_ATTACK, S_RESULT, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    ship_q, ship_d, attack_q, attack_d;
  logic [HW-1:0]   ship_total_q, ship_total_d, hit_count_q, hit_count_d;
  logic [7:0]      shot_count_q, shot_count_d;
  logic [RCW-1:0]  res_cnt_q, res_cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   col_q, col_d;
  logic [COLS-1:0] m_col_q, m_col_d;
  logic [ROWS-1:0] m_line_q, m_line_d;
  logic            rgb_r_q, rgb_r_d, rgb_g_q, rgb_g_d;
  logic            at_ready_q, at_ready_d, at_err_q, at_err_d, game_over_q, game_over_d;
`ifdef BN_CURSOR_BLINK_EN
  logic [3:0]      frame_q, frame_d;
`endif

  logic [N-1:0]  cell_sel, shown_map;
  logic [HW-1:0] map_pop;
  logic          fire_acc, coord_ok, shot_ok, is_repeat, is_ship, res_done, div_wrap;

  assign fire_acc  = at_fire && (state_q == S_ATTACK);
  assign coord_ok  = ({1'b0, at_col} < CWP'(COLS)) && ({1'b0, at_row} < RWP'(ROWS));
  assign shot_ok   = fire_acc && coord_ok;
  assign is_repeat = |(attack_q & cell_sel);
  assign is_ship   = |(ship_q & cell_sel);
  assign res_done  = (res_cnt_q == RCW'(RESULT_CYC - 1));
  assign div_wrap  = (div_q == DW'(SCAN_DIV - 1));

  // One-hot selector of the targeted cell; all-zero for out-of-range coordinates.
  always_comb begin
    cell_sel = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        cell_sel[r*COLS+c] = (at_row == RW'(r)) && (at_col == CW'(c));
  end

  always_comb begin
    map_pop = '0;
    for (int i = 0; i < N; i++) map_pop = map_pop + HW'(preset_map[i]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load) state_d = S_ARMED;
      S_ARMED:  if (!load && start && (ship_total_q != '0)) state_d = S_ATTACK;
      S_ATTACK: if (shot_ok) state_d = S_RESULT;
      S_RESULT: if (res_done) state_d = (hit_count_q == ship_total_q) ? S_OVER : S_ATTACK;
      S_OVER:   state_d = S_OVER;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ship_d       = ship_q;
    ship_total_d = ship_total_q;
    attack_d     = attack_q;
    hit_count_d  = hit_count_q;
    shot_count_d = shot_count_q;
    res_cnt_d    = (state_q == S_RESULT && !res_done) ? res_cnt_q + RCW'(1) : '0;
    if (load && (state_q == S_IDLE || state_q == S_ARMED)) begin
      ship_d       = preset_map;
      ship_total_d = map_pop;
    end
    if (shot_ok && !is_repeat) begin
      attack_d = attack_q | cell_sel;
      if (shot_count_q != 8'hFF) shot_count_d = shot_count_q + 8'd1;
      if (is_ship) hit_count_d = hit_count_q + HW'(1);
    end
    div_d = div_wrap ? '0 : div_q + DW'(1);
    col_d = col_q;
    if (div_wrap) col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
`ifdef BN_CURSOR_BLINK_EN
    frame_d = (div_wrap && col_q == CW'(COLS - 1)) ? frame_q + 4'd1 : frame_q;
`endif
  end

  // Outputs are computed from next-cycle values so every port comes straight from a flop.
  always_comb begin
    at_ready_d  = (state_d == S_ATTACK);
    at_err_d    = fire_acc && !coord_ok;
    game_over_d = (state_d == S_OVER);
    rgb_r_d     = 1'b0;
    rgb_g_d     = 1'b0;
    if (shot_ok) begin
      rgb_r_d = is_repeat || !is_ship;
      rgb_g_d = is_repeat || is_ship;
    end else if (state_q == S_RESULT && state_d == S_RESULT) begin
      rgb_r_d = rgb_r_q;
      rgb_g_d = rgb_g_q;
    end
    case (state_d)
      S_ARMED:                    shown_map = ship_d;
      S_ATTACK, S_RESULT, S_OVER: shown_map = ship_d & attack_d;
      default:                    shown_map = '0;
    endcase
    m_col_d  = '0;
    m_line_d = '0;
    for (int c = 0; c < COLS; c++) begin
      m_col_d[c] = (col_d == CW'(c));
      if (col_d == CW'(c))
        for (int r = 0; r < ROWS; r++) m_line_d[r] = shown_map[r*COLS+c];
    end
`ifdef BN_CURSOR_BLINK_EN
    if (state_d == S_ATTACK && coord_ok && frame_d[3] && col_d == at_col)
      for (int r = 0; r < ROWS; r++)
        if (at_row == RW'(r)) m_line_d[r] = ~m_line_d[r];
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      ship_q       <= '0;
      attack_q     <= '0;
      ship_total_q <= '0;
      hit_count_q  <= '0;
      shot_count_q <= '0;
      res_cnt_q    <= '0;
      div_q        <= '0;
      col_q        <= '0;
      m_col_q      <= COLS'(1);
      m_line_q     <= '0;
      rgb_r_q      <= 1'b0;
      rgb_g_q      <= 1'b0;
      at_ready_q   <= 1'b0;
      at_err_q     <= 1'b0;
      game_over_q  <= 1'b0;
`ifdef BN_CURSOR_BLINK_EN
      frame_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ship_q       <= ship_d;
      attack_q     <= attack_d;
      ship_total_q <= ship_total_d;
      hit_count_q  <= hit_count_d;
      shot_count_q <= shot_count_d;
      res_cnt_q    <= res_cnt_d;
      div_q        <= div_d;
      col_q        <= col_d;
      m_col_q      <= m_col_d;
      m_line_q     <= m_line_d;
      rgb_r_q      <= rgb_r_d;
      rgb_g_q      <= rgb_g_d;
      at_ready_q   <= at_ready_d;
      at_err_q     <= at_err_d;
      game_over_q  <= game_over_d;
`ifdef BN_CURSOR_BLINK_EN
      frame_q      <= frame_d;
`endif
    end
  end

  assign at_ready   = at_ready_q;
  assign at_err     = at_err_q;
  assign m_col      = m_col_q;
  assign m_line     = m_line_q;
  assign rgb_r      = rgb_r_q;
  assign rgb_g      = rgb_g_q;
  assign hit_count  = hit_count_q;
  assign shot_count = shot_count_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_modulo_batalha_naval_param.sv
// Testbench for modulo_batalha_naval_param (5x7 board, SCAN_DIV=4, RESULT_CYC=3).
// Per-cycle vectors push expected outputs into a scoreboard queue that is popped after each edge.
module tb_modulo_batalha_naval_param;

  localparam int COLS = 5;
  localparam int ROWS = 7;
  localparam int N    = 35;

  logic          clk = 1'b0;
  logic          clr, load, start, at_fire;
  logic [N-1:0]  preset_map;
  logic [2:0]    at_col, at_row;
  logic          at_ready, at_err, rgb_r, rgb_g, game_over;
  logic [4:0]    m_col;
  logic [6:0]    m_line;
  logic [5:0]    hit_count;
  logic [7:0]    shot_count;

  always #5 clk = ~clk;

  modulo_batalha_naval_param #(
    .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(4), .RESULT_CYC(3)
  ) dut (
    .clk(clk), .clr(clr), .load(load), .preset_map(preset_map), .start(start),
    .at_col(at_col), .at_row(at_row), .at_fire(at_fire),
    .at_ready(at_ready), .at_err(at_err), .m_col(m_col), .m_line(m_line),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .hit_count(hit_count), .shot_count(shot_count),
    .game_over(game_over)
  );

  typedef struct {
    int         id;
    logic       at_ready, at_err, rgb_r, rgb_g, game_over;
    int         hit, shot;
    bit         chk_scan;
    logic [4:0] m_col;
    logic [6:0] m_line;
  } exp_t;

  typedef struct {
    bit         clr, load, start, fire;
    logic [2:0] col, row;
    logic [N-1:0] preset;
    exp_t       exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mkv(input int id, input bit c, l, s, f, input int col, row,
                               input logic [N-1:0] pre, input bit rdy, err, r, g, go,
                               input int hit, shot, input bit chk,
                               input logic [4:0] mc, input logic [6:0] ml);
    vec_t v;
    v.clr = c; v.load = l; v.start = s; v.fire = f;
    v.col = 3'(col); v.row = 3'(row); v.preset = pre;
    v.exp.id = id; v.exp.at_ready = rdy; v.exp.at_err = err;
    v.exp.rgb_r = r; v.exp.rgb_g = g; v.exp.game_over = go;
    v.exp.hit = hit; v.exp.shot = shot; v.exp.chk_scan = chk;
    v.exp.m_col = mc; v.exp.m_line = ml;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    clr = v.clr; load = v.load; start = v.start; at_fire = v.fire;
    at_col = v.col; at_row = v.row; preset_map = v.preset;
    sb_q.push_back(v.exp);
  endtask

  task automatic cmpVal(input string what, input int id, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s (item %0d): got %0h, expected %0h", what, id, act, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected at least 1");
      return;
    end
    e = sb_q.pop_front();
    cmpVal("at_ready",   e.id, 32'(at_ready),   32'(e.at_ready));
    cmpVal("at_err",     e.id, 32'(at_err),     32'(e.at_err));
    cmpVal("rgb_r",      e.id, 32'(rgb_r),      32'(e.rgb_r));
    cmpVal("rgb_g",      e.id, 32'(rgb_g),      32'(e.rgb_g));
    cmpVal("game_over",  e.id, 32'(game_over),  32'(e.game_over));
    cmpVal("hit_count",  e.id, 32'(hit_count),  e.hit);
    cmpVal("shot_count", e.id, 32'(shot_count), e.shot);
    if (e.chk_scan) begin
      cmpVal("m_col",  e.id, 32'(m_col),  32'(e.m_col));
      cmpVal("m_line", e.id, 32'(m_line), 32'(e.m_line));
    end
  endtask

  task automatic stepCheck(input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [N-1:0] p3, p1, pz, plast, diag;
    int col;
    p3 = 35'h3; p1 = 35'h1; pz = '0; plast = {1'b1, 34'b0};
    diag = '0;
    for (int c = 0; c < COLS; c++) diag[c*COLS+c] = 1'b1;

    clr = 1'b1; load = 1'b0; start = 1'b0; at_fire = 1'b0;
    at_col = '0; at_row = '0; preset_map = '0;

    //           id  clr ld st fr col row pre    rdy err r g go hit shot chk mcol     mline
    tbl.push_back(mkv( 0, 1,0,0,0, 0,0, p3,    0,0,0,0,0, 0,0, 1,5'b00001,7'h00));
    tbl.push_back(mkv( 1, 1,0,0,0, 0,0, p3,    0,0,0,0,0, 0,0, 1,5'b00001,7'h00));
    tbl.push_back(mkv( 2, 0,1,0,0, 0,0, p3,    0,0,0,0,0, 0,0, 1,5'b00001,7'h01));
    tbl.push_back(mkv( 3, 0,0,1,0, 0,0, p3,    1,0,0,0,0, 0,0, 1,5'b00001,7'h00));
    tbl.push_back(mkv( 4, 0,0,0,1, 0,0, p3,    0,0,0,1,0, 1,1, 1,5'b00001,7'h01));
    tbl.push_back(mkv( 5, 0,0,0,1, 1,0, p3,    0,0,0,1,0, 1,1, 1,5'b00010,7'h00));
    tbl.push_back(mkv( 6, 0,0,0,1, 1,0, p3,    0,0,0,1,0, 1,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv( 7, 0,0,0,0, 1,0, p3,    1,0,0,0,0, 1,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv( 8, 0,0,0,1, 1,0, p3,    0,0,0,1,0, 2,2, 0,5'b00000,7'h00));
    tbl.push_back(mkv( 9, 0,0,0,0, 1,0, p3,    0,0,0,1,0, 2,2, 0,5'b00000,7'h00));
    tbl.push_back(mkv(10, 0,0,0,0, 1,0, p3,    0,0,0,1,0, 2,2, 0,5'b00000,7'h00));
    tbl.push_back(mkv(11, 0,0,0,0, 1,0, p3,    0,0,0,0,1, 2,2, 0,5'b00000,7'h00));
    tbl.push_back(mkv(12, 0,0,0,1, 0,0, p3,    0,0,0,0,1, 2,2, 0,5'b00000,7'h00));
    tbl.push_back(mkv(13, 0,1,1,0, 0,0, p3,    0,0,0,0,1, 2,2, 0,5'b00000,7'h00));
    tbl.push_back(mkv(14, 1,0,0,0, 0,0, p1,    0,0,0,0,0, 0,0, 1,5'b00001,7'h00));
    tbl.push_back(mkv(15, 0,1,0,0, 0,0, p1,    0,0,0,0,0, 0,0, 0,5'b00000,7'h00));
    tbl.push_back(mkv(16, 0,0,1,0, 0,0, p1,    1,0,0,0,0, 0,0, 0,5'b00000,7'h00));
    tbl.push_back(mkv(17, 0,0,0,1, 3,2, p1,    0,0,1,0,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(18, 0,0,0,0, 3,2, p1,    0,0,1,0,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(19, 0,0,0,0, 3,2, p1,    0,0,1,0,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(20, 0,0,0,0, 3,2, p1,    1,0,0,0,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(21, 0,0,0,1, 3,2, p1,    0,0,1,1,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(22, 0,0,0,0, 3,2, p1,    0,0,1,1,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(23, 0,0,0,0, 3,2, p1,    0,0,1,1,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(24, 0,0,0,0, 3,2, p1,    1,0,0,0,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(25, 0,0,0,1, 6,0, p1,    1,1,0,0,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(26, 0,0,0,0, 6,0, p1,    1,0,0,0,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(27, 0,0,0,1, 0,7, p1,    1,1,0,0,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(28, 0,0,0,0, 0,7, p1,    1,0,0,0,0, 0,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(29, 1,0,0,0, 0,0, pz,    0,0,0,0,0, 0,0, 0,5'b00000,7'h00));
    tbl.push_back(mkv(30, 0,1,0,0, 0,0, pz,    0,0,0,0,0, 0,0, 0,5'b00000,7'h00));
    tbl.push_back(mkv(31, 0,0,1,0, 0,0, pz,    0,0,0,0,0, 0,0, 0,5'b00000,7'h00));
    tbl.push_back(mkv(32, 0,1,1,0, 0,0, plast, 0,0,0,0,0, 0,0, 0,5'b00000,7'h00));
    tbl.push_back(mkv(33, 0,0,1,0, 0,0, plast, 1,0,0,0,0, 0,0, 0,5'b00000,7'h00));
    tbl.push_back(mkv(34, 0,0,0,1, 4,6, plast, 0,0,0,1,0, 1,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(35, 0,0,0,0, 4,6, plast, 0,0,0,1,0, 1,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(36, 0,0,0,0, 4,6, plast, 0,0,0,1,0, 1,1, 0,5'b00000,7'h00));
    tbl.push_back(mkv(37, 0,0,0,0, 4,6, plast, 0,0,0,0,1, 1,1, 0,5'b00000,7'h00));

    for (int i = 0; i < tbl.size(); i++) stepCheck(tbl[i]);

    // Scan walk in ARMED on a diagonal map; clr must override a simultaneous load.
    stepCheck(mkv(100, 1,1,0,0, 0,0, diag, 0,0,0,0,0, 0,0, 1,5'b00001,7'h00));
    stepCheck(mkv(101, 1,1,0,0, 0,0, diag, 0,0,0,0,0, 0,0, 1,5'b00001,7'h00));
    for (int j = 1; j < 24; j++) begin
      col = (j / 4) % 5;
      stepCheck(mkv(101 + j, 0, (j == 1), 0, 0, 0, 0, diag, 0,0,0,0,0, 0,0, 1,
                    5'(1 << col), 7'(1 << col)));
    end

    // Reset in the middle of a RESULT window.
    stepCheck(mkv(200, 0,1,0,0, 0,0, p1, 0,0,0,0,0, 0,0, 0,5'b00000,7'h00));
    stepCheck(mkv(201, 0,0,1,0, 0,0, p1, 1,0,0,0,0, 0,0, 0,5'b00000,7'h00));
    stepCheck(mkv(202, 0,0,0,1, 0,0, p1, 0,0,0,1,0, 1,1, 0,5'b00000,7'h00));
    stepCheck(mkv(203, 1,0,0,0, 0,0, p1, 0,0,0,0,0, 0,0, 1,5'b00001,7'h00));
    stepCheck(mkv(204, 0,0,1,0, 0,0, p1, 0,0,0,0,0, 0,0, 0,5'b00000,7'h00));

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
